shift_seq: RTL and testbench

Command sequencer placed directly upstream of the 8-bit shift register. It accepts a byte over a valid/ready handshake and turns it into the register's command stream: one load, then NSHIFT logical-right-shift commands spaced DIV cycles apart. It then pulses `done` and returns to idle. The outputs `sh_en`, `sh_ctrl` and `sh_din` connect one-to-one to the shift register's `en`, `ctrl` and `din` inputs.

---
 rtl/shift_seq_if.sv | 21 ++
 rtl/shift_seq.sv | 124 ++++++++++++
 tb/tb_shift_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_if.sv
// Byte handshake plus the command bus that feeds the downstream 8-bit shift register.
interface shift_seq_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       sh_en;
    logic [2:0] sh_ctrl;
    logic [7:0] sh_din;
    logic       busy;
    logic       done;

    modport master (
        output in_valid, in_data,
        input  in_ready, sh_en, sh_ctrl, sh_din, busy, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, sh_en, sh_ctrl, sh_din, busy, done
    );
endinterface

// File: rtl/shift_seq.sv
// Turns one accepted byte into a load command followed by NSHIFT right-shift
// commands spaced DIV cycles apart, then pulses done and returns to idle.
module shift_seq #(
    parameter int unsigned DIV    = 4,
    parameter int unsigned NSHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    shift_seq_if.slave  bus
);
    localparam logic [7:0] DIV_RELOAD  = 8'(DIV - 1);
    localparam logic [7:0] NSHIFT_LAST = 8'(NSHIFT);
    localparam bit         DIV_ONE     = (DIV == 1);

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_SHIFT = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [7:0] shift_cnt_q, shift_cnt_d;
    logic [7:0] din_q, din_d;
    logic       en_q, en_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       accept;

    assign bus.in_ready = (state_q == S_IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        shift_cnt_d = shift_cnt_q;
        din_d       = din_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_LOAD;
                    din_d   = bus.in_data;
                end
            end
            S_LOAD: begin
                if (DIV_ONE) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d   = S_WAIT;
                    div_cnt_d = DIV_RELOAD;
                end
            end
            S_WAIT: begin
                if (div_cnt_q <= 8'd1) begin
                    state_d = S_SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
            S_SHIFT: begin
                shift_cnt_d = shift_cnt_q + 8'd1;
                if (shift_cnt_d == NSHIFT_LAST) begin
                    state_d = S_DONE;
                end else if (DIV_ONE) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d   = S_WAIT;
                    div_cnt_d = DIV_RELOAD;
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                div_cnt_d   = '0;
                shift_cnt_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        en_d   = (state_d == S_LOAD) || (state_d == S_SHIFT);
        ctrl_d = (state_d == S_LOAD)  ? CMD_LOAD  :
                 (state_d == S_SHIFT) ? CMD_SHIFT : CMD_NOP;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            shift_cnt_q <= '0;
            din_q       <= '0;
            en_q        <= 1'b0;
            ctrl_q      <= CMD_NOP;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            shift_cnt_q <= shift_cnt_d;
            din_q       <= din_d;
            en_q        <= en_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.sh_en   = en_q;
    assign bus.sh_ctrl = ctrl_q;
    assign bus.sh_din  = din_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_shift_seq.sv
// Three sequencers with different DIV/NSHIFT checked every cycle against a
// timeline model (offset from the handshake), plus hand-computed expectations.
module tb_shift_seq;
    logic       clk;
    logic [2:0] rst;
    logic [2:0] vld;
    logic [7:0] dat [3];
    int         cyc;
    int         checks;
    int         failures;

    shift_seq_if b0 ();
    shift_seq_if b1 ();
    shift_seq_if b2 ();

    shift_seq #(.DIV(4), .NSHIFT(8)) u0 (.clk(clk), .rst(rst[0]), .bus(b0));
    shift_seq #(.DIV(4), .NSHIFT(3)) u1 (.clk(clk), .rst(rst[1]), .bus(b1));
    shift_seq #(.DIV(1), .NSHIFT(8)) u2 (.clk(clk), .rst(rst[2]), .bus(b2));

    assign b0.in_valid = vld[0];
    assign b1.in_valid = vld[1];
    assign b2.in_valid = vld[2];
    assign b0.in_data  = dat[0];
    assign b1.in_data  = dat[1];
    assign b2.in_data  = dat[2];

    logic       rdy  [3];
    logic       en   [3];
    logic [2:0] ctrl [3];
    logic [7:0] din  [3];
    logic       busy [3];
    logic       done [3];

    assign rdy[0] = b0.in_ready;  assign rdy[1] = b1.in_ready;  assign rdy[2] = b2.in_ready;
    assign en[0]  = b0.sh_en;     assign en[1]  = b1.sh_en;     assign en[2]  = b2.sh_en;
    assign ctrl[0] = b0.sh_ctrl;  assign ctrl[1] = b1.sh_ctrl;  assign ctrl[2] = b2.sh_ctrl;
    assign din[0] = b0.sh_din;    assign din[1] = b1.sh_din;    assign din[2] = b2.sh_din;
    assign busy[0] = b0.busy;     assign busy[1] = b1.busy;     assign busy[2] = b2.busy;
    assign done[0] = b0.done;     assign done[1] = b1.done;     assign done[2] = b2.done;

    int DV [3] = '{4, 4, 1};
    int NS [3] = '{8, 3, 8};

    // Model: per instance, whether a sequence runs and the cycle offset t from its handshake.
    bit         m_act  [3];
    int         m_t    [3];
    logic [7:0] m_data [3];

    logic [7:0] dout [3];
    int         hs_q   [3][$];
    int         done_q [3][$];
    int         cmd_q  [3][$];
    logic [7:0] ldd_q  [3][$];
    logic [7:0] shv_q  [3][$];

    bit         e_ld, e_sh, e_dn, e_busy, e_rdy;
    logic [2:0] e_ctrl;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h exp=%0h", nm, i, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                if (m_act[i]) begin
                    e_ld   = (m_t[i] == 1);
                    e_sh   = (m_t[i] > 1) && (m_t[i] <= 1 + NS[i] * DV[i]) && (((m_t[i] - 1) % DV[i]) == 0);
                    e_dn   = (m_t[i] == 2 + NS[i] * DV[i]);
                    e_busy = 1'b1;
                    e_rdy  = 1'b0;
                end else begin
                    e_ld   = 1'b0;
                    e_sh   = 1'b0;
                    e_dn   = 1'b0;
                    e_busy = 1'b0;
                    e_rdy  = !rst[i];
                end
                e_ctrl = e_ld ? 3'b001 : (e_sh ? 3'b010 : 3'b000);
                check("in_ready", i, 32'(rdy[i]),  32'(e_rdy));
                check("sh_en",    i, 32'(en[i]),   32'(e_ld | e_sh));
                check("sh_ctrl",  i, 32'(ctrl[i]), 32'(e_ctrl));
                check("busy",     i, 32'(busy[i]), 32'(e_busy));
                check("done",     i, 32'(done[i]), 32'(e_dn));
                check("sh_din",   i, 32'(din[i]),  32'(m_data[i]));

                // Downstream register and event logs
                if (vld[i] && rdy[i]) hs_q[i].push_back(cyc);
                if (done[i]) done_q[i].push_back(cyc);
                if (en[i]) begin
                    cmd_q[i].push_back(cyc);
                    if (ctrl[i] == 3'b001) begin
                        dout[i] = din[i];
                        ldd_q[i].push_back(din[i]);
                    end else if (ctrl[i] == 3'b010) begin
                        dout[i] = dout[i] >> 1;
                        shv_q[i].push_back(dout[i]);
                    end
                end

                if (rst[i]) begin
                    m_act[i]  = 1'b0;
                    m_data[i] = '0;
                end else if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == 3 + NS[i] * DV[i]) m_act[i] = 1'b0;
                end else if (vld[i]) begin
                    m_act[i]  = 1'b1;
                    m_t[i]    = 1;
                    m_data[i] = dat[i];
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int i, input int n, input int budget);
        int k = 0;
        while (hs_q[i].size() <= n && k < budget) begin
            step(1);
            k++;
        end
        if (hs_q[i].size() <= n) begin
            checks++;
            failures++;
            $display("FAIL hs_timeout[%0d] got=%0d handshakes exp=%0d", i, hs_q[i].size(), n + 1);
        end
    endtask

    logic [7:0] exp_sh [8] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    logic [7:0] fin [3];
    int         n_hs;
    int         rst_cyc;
    int         first_cmd;

    initial begin
        cyc = 0; checks = 0; failures = 0;
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_data[i] = '0; dout[i] = '0; dat[i] = '0;
        end
        rst = '1;
        vld = '0;
        step(3);
        rst = '0;
        step(2);

        // Three sequences in parallel; in_data churns after the handshake
        dat[0] = 8'hA5; dat[1] = 8'hA5; dat[2] = 8'hFF;
        vld = '1;
        wait_hs(0, 0, 10);
        wait_hs(1, 0, 10);
        wait_hs(2, 0, 10);
        vld = '0;
        for (int k = 0; k < 40; k++) begin
            dat[0] = ~dat[0];
            dat[1] = dat[1] + 8'h13;
            dat[2] = ~dat[2];
            step(1);
        end
        for (int i = 0; i < 3; i++) fin[i] = dout[i];

        // in_valid held across two bytes
        dat[0] = 8'h81; vld[0] = 1'b1;
        wait_hs(0, 1, 10);
        dat[0] = 8'h42;
        wait_hs(0, 2, 60);
        vld[0] = 1'b0;
        step(40);

        // Reset coinciding with a handshake attempt in idle
        n_hs = hs_q[0].size();
        rst[0] = 1'b1; vld[0] = 1'b1; dat[0] = 8'h77;
        step(1);
        rst[0] = 1'b0; vld[0] = 1'b0;
        step(1);
        check("rst_wins_hs", 0, 32'(hs_q[0].size()), 32'(n_hs));

        // Reset at c10 of a running sequence, new byte right after
        dat[0] = 8'h3C; vld[0] = 1'b1;
        wait_hs(0, n_hs, 10);
        vld[0] = 1'b0;
        step(9);
        rst[0] = 1'b1;
        rst_cyc = cyc;
        step(1);
        rst[0] = 1'b0; vld[0] = 1'b1; dat[0] = 8'h5A;
        wait_hs(0, n_hs + 1, 10);
        vld[0] = 1'b0;
        step(40);

        // Hand-computed expectations
        check("u0_load_val",   0, 32'(ldd_q[0][0]), 32'h A5);
        check("u0_done_ofs",   0, 32'(done_q[0][0] - hs_q[0][0]), 32'd34);
        check("u0_final",      0, 32'(fin[0]), 32'h00);
        check("u1_done_ofs",   1, 32'(done_q[1][0] - hs_q[1][0]), 32'd14);
        check("u1_final",      1, 32'(fin[1]), 32'h14);
        check("u2_done_ofs",   2, 32'(done_q[2][0] - hs_q[2][0]), 32'd10);
        check("u2_nshift",     2, 32'(shv_q[2].size()), 32'd8);
        for (int k = 0; k < 8; k++) check("u2_shift_val", 2, 32'(shv_q[2][k]), 32'(exp_sh[k]));
        check("hold_gap",      0, 32'(hs_q[0][2] - hs_q[0][1]), 32'd35);
        check("hold_byte1",    0, 32'(ldd_q[0][1]), 32'h81);
        check("hold_byte2",    0, 32'(ldd_q[0][2]), 32'h42);
        check("rst_at_c10",    0, 32'(rst_cyc - hs_q[0][n_hs]), 32'd10);
        check("rst_rehs",      0, 32'(hs_q[0][n_hs + 1]), 32'(rst_cyc + 1));
        first_cmd = 0;
        foreach (cmd_q[0][k]) if (first_cmd == 0 && cmd_q[0][k] > rst_cyc) first_cmd = cmd_q[0][k];
        check("rst_quiet",     0, 32'(first_cmd), 32'(rst_cyc + 2));
        check("n_loads",       0, 32'(ldd_q[0].size()), 32'd5);
        check("load_after_rst", 0, 32'(ldd_q[0][4]), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
